// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Contents: CSR address type and constants, FSM state enum, mstatus bit
// positions and interrupt cause codes.
package trap_ctrl_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] word_t;

  localparam csr_addr_t ISA_CSR_ADDR_MSTATUS  = 12'h300;
  localparam csr_addr_t ISA_CSR_ADDR_MIE      = 12'h304;
  localparam csr_addr_t ISA_CSR_ADDR_MTVEC    = 12'h305;
  localparam csr_addr_t ISA_CSR_ADDR_MEPC     = 12'h341;
  localparam csr_addr_t ISA_CSR_ADDR_MCAUSE   = 12'h342;
  localparam csr_addr_t ISA_CSR_ADDR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_STATUS = 3'd3,
    T_VEC    = 3'd4,
    M_STATUS = 3'd5,
    M_EPC    = 3'd6
  } trap_state_t;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_CODE_EXT   = 11;
  localparam int IRQ_CODE_TIMER = 7;
  localparam int IRQ_CODE_SW    = 3;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Combinational interrupt pending/priority encoder.
// Ports: global enable (mstatus.MIE), per-source enables and levels in;
// irq_take (some enabled interrupt pending) and irq_cause (mcause value) out.
module irq_prio
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            mstatus_mie,
  input  logic            mie_ext,
  input  logic            mie_sw,
  input  logic            mie_timer,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  output logic            irq_take,
  output logic [XLEN-1:0] irq_cause
);

  logic w_ext;
  logic w_sw;
  logic w_timer;

  assign w_ext   = mstatus_mie & irq_ext   & mie_ext;
  assign w_sw    = mstatus_mie & irq_sw    & mie_sw;
  assign w_timer = mstatus_mie & irq_timer & mie_timer;

  assign irq_take = w_ext | w_sw | w_timer;

  // Fixed priority: external, then software, then timer.
  always_comb begin
    irq_cause = '0;
    if (w_ext)        irq_cause = {1'b1, (XLEN-1)'(IRQ_CODE_EXT)};
    else if (w_sw)    irq_cause = {1'b1, (XLEN-1)'(IRQ_CODE_SW)};
    else if (w_timer) irq_cause = {1'b1, (XLEN-1)'(IRQ_CODE_TIMER)};
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer and sole master of the CSR file write port.
// Ports: core CSR access (csr_*), exception/interrupt/MRET requests, trap_ack,
// busy, fetch redirect, CSR file interface (cf_*).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            irq_boundary,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mret_valid,
  output logic            trap_ack,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            cf_write_en,
  output logic [11:0]     cf_addr,
  output logic [XLEN-1:0] cf_din,
  input  logic [XLEN-1:0] cf_dout,
  input  logic [XLEN-1:0] cf_mstatus
);

  trap_state_t     r_state;
  trap_state_t     w_next;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [2:0]      r_mie_shadow;   // {ext, timer, sw} enables

  logic            w_irq_take;
  logic [XLEN-1:0] w_irq_cause;
  logic            w_idle;
  logic            w_acc_exc;
  logic            w_acc_irq;
  logic            w_acc_mret;
  logic            w_grant;
  logic [XLEN-1:0] w_base;

  irq_prio #(.XLEN(XLEN)) u_irq_prio (
    .mstatus_mie (cf_mstatus[MSTATUS_MIE]),
    .mie_ext     (r_mie_shadow[2]),
    .mie_sw      (r_mie_shadow[0]),
    .mie_timer   (r_mie_shadow[1]),
    .irq_ext     (irq_ext),
    .irq_sw      (irq_sw),
    .irq_timer   (irq_timer),
    .irq_take    (w_irq_take),
    .irq_cause   (w_irq_cause)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_acc_exc  = w_idle & exc_valid;
  assign w_acc_irq  = w_idle & ~exc_valid & w_irq_take & irq_boundary;
  assign w_acc_mret = w_idle & ~exc_valid & ~(w_irq_take & irq_boundary) & mret_valid;
  assign w_grant    = w_idle & ~w_acc_exc & ~w_acc_irq & ~w_acc_mret & csr_valid;
  assign w_base     = cf_dout & ~(XLEN'(3));

  // State register plus the per-trap latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cause      <= '0;
      r_epc        <= '0;
      r_mie_shadow <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_exc) begin
        r_cause <= exc_cause;
        r_epc   <= trap_epc;
      end else if (w_acc_irq) begin
        r_cause <= w_irq_cause;
        r_epc   <= trap_epc;
      end
      if (w_grant && csr_we && (csr_addr == ISA_CSR_ADDR_MIE)) begin
        r_mie_shadow <= {csr_wdata[IRQ_CODE_EXT], csr_wdata[IRQ_CODE_TIMER],
                         csr_wdata[IRQ_CODE_SW]};
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc_exc || w_acc_irq) w_next = T_EPC;
        else if (w_acc_mret)        w_next = M_STATUS;
      end
      T_EPC:    w_next = T_CAUSE;
      T_CAUSE:  w_next = T_STATUS;
      T_STATUS: w_next = T_VEC;
      T_VEC:    w_next = IDLE;
      M_STATUS: w_next = M_EPC;
      M_EPC:    w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    csr_ready      = 1'b0;
    csr_rdata      = '0;
    trap_ack       = 1'b0;
    busy           = ~w_idle;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cf_write_en    = 1'b0;
    cf_addr        = '0;
    cf_din         = '0;
    case (r_state)
      IDLE: begin
        trap_ack = w_acc_exc | w_acc_irq | w_acc_mret;
        if (w_grant) begin
          csr_ready   = 1'b1;
          cf_addr     = csr_addr;
          cf_din      = csr_wdata;
          csr_rdata   = cf_dout;
          // mhartid is read-only: the read completes, the write is dropped
          cf_write_en = csr_we & (csr_addr != ISA_CSR_ADDR_MHARTID);
        end
      end
      T_EPC: begin
        cf_write_en = 1'b1;
        cf_addr     = ISA_CSR_ADDR_MEPC;
        cf_din      = r_epc;
      end
      T_CAUSE: begin
        cf_write_en = 1'b1;
        cf_addr     = ISA_CSR_ADDR_MCAUSE;
        cf_din      = r_cause;
      end
      T_STATUS: begin
        cf_write_en = 1'b1;
        cf_addr     = ISA_CSR_ADDR_MSTATUS;
        cf_din      = cf_mstatus;
        cf_din[MSTATUS_MPIE] = cf_mstatus[MSTATUS_MIE];
        cf_din[MSTATUS_MIE]  = 1'b0;
        cf_din[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      T_VEC: begin
        cf_addr        = ISA_CSR_ADDR_MTVEC;
        redirect_valid = 1'b1;
        // Vectored mode only applies to interrupts
        if (VEC_EN && (cf_dout[1:0] == 2'b01) && r_cause[XLEN-1])
          redirect_pc = w_base + {r_cause[XLEN-3:0], 2'b00};
        else
          redirect_pc = w_base;
      end
      M_STATUS: begin
        cf_write_en = 1'b1;
        cf_addr     = ISA_CSR_ADDR_MSTATUS;
        cf_din      = cf_mstatus;
        cf_din[MSTATUS_MIE]  = cf_mstatus[MSTATUS_MPIE];
        cf_din[MSTATUS_MPIE] = 1'b1;
        cf_din[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      M_EPC: begin
        cf_addr        = ISA_CSR_ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = w_base;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic        csr_ready;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_cause = '0;
  logic [31:0] trap_epc = '0;
  logic        irq_boundary = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_timer = 1'b0;
  logic        mret_valid = 1'b0;
  logic        trap_ack;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        cf_write_en;
  logic [11:0] cf_addr;
  logic [31:0] cf_din;
  logic [31:0] cf_dout;
  logic [31:0] cf_mstatus;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .VEC_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .trap_epc(trap_epc),
    .irq_boundary(irq_boundary), .irq_ext(irq_ext), .irq_sw(irq_sw),
    .irq_timer(irq_timer), .mret_valid(mret_valid), .trap_ack(trap_ack),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cf_write_en(cf_write_en), .cf_addr(cf_addr), .cf_din(cf_din),
    .cf_dout(cf_dout), .cf_mstatus(cf_mstatus)
  );

  // Small CSR file model; mhartid reads as 0 and is never writable
  logic [31:0] m_mstatus  = '0;
  logic [31:0] m_mie      = '0;
  logic [31:0] m_mtvec    = '0;
  logic [31:0] m_mepc     = '0;
  logic [31:0] m_mcause   = '0;
  logic [31:0] m_mscratch = '0;
  logic        hartid_wr  = 1'b0;

  always_comb begin
    cf_dout = '0;
    case (cf_addr)
      12'h300: cf_dout = m_mstatus;
      12'h304: cf_dout = m_mie;
      12'h305: cf_dout = m_mtvec;
      12'h340: cf_dout = m_mscratch;
      12'h341: cf_dout = m_mepc;
      12'h342: cf_dout = m_mcause;
      default: cf_dout = '0;
    endcase
  end
  assign cf_mstatus = m_mstatus;

  always @(posedge clk) begin
    if (cf_write_en) begin
      case (cf_addr)
        12'h300: m_mstatus  <= cf_din;
        12'h304: m_mie      <= cf_din;
        12'h305: m_mtvec    <= cf_din;
        12'h340: m_mscratch <= cf_din;
        12'h341: m_mepc     <= cf_din;
        12'h342: m_mcause   <= cf_din;
        12'hF14: hartid_wr  <= 1'b1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    #1;
    chk("csr_wr_ready", {31'd0, csr_ready}, 32'd1);
    tick();
    csr_valid = 1'b0; csr_we = 1'b0;
  endtask

  task automatic idle_outputs_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, csr_ready}, 32'd0);
    chk({tag, "_ack"},   {31'd0, trap_ack}, 32'd0);
    chk({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_we"},    {31'd0, cf_write_en}, 32'd0);
    chk({tag, "_rpc"},   redirect_pc, 32'd0);
    chk({tag, "_addr"},  {20'd0, cf_addr}, 32'd0);
    chk({tag, "_din"},   cf_din, 32'd0);
    chk({tag, "_rdata"}, csr_rdata, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    idle_outputs_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Core write then read of mscratch, zero wait states
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_ready", {31'd0, csr_ready}, 32'd1);
    chk("wr_we",    {31'd0, cf_write_en}, 32'd1);
    chk("wr_addr",  {20'd0, cf_addr}, 32'h340);
    chk("wr_din",   cf_din, 32'hDEADBEEF);
    tick();
    csr_we = 1'b0;
    #1;
    chk("rd_ready", {31'd0, csr_ready}, 32'd1);
    chk("rd_data",  csr_rdata, 32'hDEADBEEF);
    tick();

    // mhartid write suppressed, read completes
    csr_we = 1'b1; csr_addr = 12'hF14; csr_wdata = 32'd5;
    #1;
    chk("hartid_we",    {31'd0, cf_write_en}, 32'd0);
    chk("hartid_ready", {31'd0, csr_ready}, 32'd1);
    tick();
    csr_we = 1'b0;
    #1;
    chk("hartid_rd",    csr_rdata, 32'd0);
    chk("hartid_nowr",  {31'd0, hartid_wr}, 32'd0);
    tick();
    csr_valid = 1'b0;

    // Synchronous exception, direct mtvec
    csr_wr(12'h305, 32'h1000);
    csr_wr(12'h300, 32'h8);
    exc_valid = 1'b1; exc_cause = 32'd2; trap_epc = 32'h200;
    csr_valid = 1'b1; csr_we = 1'b0; csr_addr = 12'h340;   // loses to the trap
    #1;
    chk("exc_ack",       {31'd0, trap_ack}, 32'd1);
    chk("exc_csr_block", {31'd0, csr_ready}, 32'd0);
    chk("exc_busy0",     {31'd0, busy}, 32'd0);
    tick();
    exc_valid = 1'b0;
    chk("exc_t1_busy",  {31'd0, busy}, 32'd1);
    chk("exc_t1_ready", {31'd0, csr_ready}, 32'd0);
    chk("exc_t1_ack",   {31'd0, trap_ack}, 32'd0);
    chk("exc_t1_addr",  {20'd0, cf_addr}, 32'h341);
    chk("exc_t1_din",   cf_din, 32'h200);
    tick();
    chk("exc_t2_busy",  {31'd0, busy}, 32'd1);
    chk("exc_t2_addr",  {20'd0, cf_addr}, 32'h342);
    chk("exc_t2_din",   cf_din, 32'd2);
    tick();
    chk("exc_t3_busy",  {31'd0, busy}, 32'd1);
    chk("exc_t3_addr",  {20'd0, cf_addr}, 32'h300);
    chk("exc_t3_din",   cf_din, 32'h1880);
    tick();
    chk("exc_t4_busy",  {31'd0, busy}, 32'd1);
    chk("exc_t4_we",    {31'd0, cf_write_en}, 32'd0);
    chk("exc_t4_rv",    {31'd0, redirect_valid}, 32'd1);
    chk("exc_t4_pc",    redirect_pc, 32'h1000);
    tick();
    chk("exc_t5_busy",  {31'd0, busy}, 32'd0);
    chk("exc_t5_rv",    {31'd0, redirect_valid}, 32'd0);
    chk("exc_t5_ready", {31'd0, csr_ready}, 32'd1);
    chk("exc_mepc",     m_mepc, 32'h200);
    chk("exc_mcause",   m_mcause, 32'd2);
    chk("exc_mstatus",  m_mstatus, 32'h1880);
    tick();
    csr_valid = 1'b0;

    // mstatus.MIE is now 0: enabled interrupt must not be taken
    csr_wr(12'h304, 32'h800);
    irq_ext = 1'b1; irq_boundary = 1'b1;
    #1;
    chk("irq_gmie_off", {31'd0, trap_ack}, 32'd0);
    irq_boundary = 1'b0;
    tick();

    // Vectored external interrupt, ext beats timer
    csr_wr(12'h305, 32'h1001);
    csr_wr(12'h300, 32'h8);
    irq_ext = 1'b1; irq_timer = 1'b1; irq_boundary = 1'b0; trap_epc = 32'h300;
    #1;
    chk("irq_no_boundary", {31'd0, trap_ack}, 32'd0);
    irq_boundary = 1'b1;
    #1;
    chk("irq_ack", {31'd0, trap_ack}, 32'd1);
    tick();
    irq_ext = 1'b0; irq_timer = 1'b0; irq_boundary = 1'b0;
    chk("irq_t1_din", cf_din, 32'h300);
    tick();
    chk("irq_t2_din", cf_din, 32'h8000000B);
    tick();
    chk("irq_t3_din", cf_din, 32'h1880);
    tick();
    chk("irq_t4_rv",  {31'd0, redirect_valid}, 32'd1);
    chk("irq_t4_pc",  redirect_pc, 32'h102C);
    tick();
    chk("irq_done_busy", {31'd0, busy}, 32'd0);
    chk("irq_mcause",    m_mcause, 32'h8000000B);

    // MRET
    mret_valid = 1'b1;
    #1;
    chk("mret_ack", {31'd0, trap_ack}, 32'd1);
    tick();
    mret_valid = 1'b0;
    chk("mret_t1_addr", {20'd0, cf_addr}, 32'h300);
    chk("mret_t1_din",  cf_din, 32'h1888);
    tick();
    chk("mret_t2_rv",   {31'd0, redirect_valid}, 32'd1);
    chk("mret_t2_pc",   redirect_pc, 32'h300);
    tick();
    chk("mret_done_busy", {31'd0, busy}, 32'd0);
    chk("mret_mie_bits",  m_mstatus & 32'h88, 32'h88);

    // Reset during T_CAUSE aborts with no redirect
    exc_valid = 1'b1; exc_cause = 32'd4; trap_epc = 32'h400;
    tick();
    exc_valid = 1'b0;
    tick();
    chk("rst_in_tcause", {29'd0, cf_addr == 12'h342, cf_write_en, busy}, 32'd7);
    rst = 1'b1;
    #1;
    idle_outputs_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_rv", {31'd0, redirect_valid}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
    end
    chk("rst_mcause_kept", m_mcause, 32'h8000000B);
    // mstatus.MIE = 1 and the line is high, but mie_shadow was cleared
    irq_ext = 1'b1; irq_boundary = 1'b1;
    csr_valid = 1'b1; csr_we = 1'b0; csr_addr = 12'h340;
    #1;
    chk("rst_shadow_clr", {31'd0, trap_ack}, 32'd0);
    chk("rst_grant",      {31'd0, csr_ready}, 32'd1);
    chk("rst_grant_data", csr_rdata, 32'hDEADBEEF);
    tick();
    csr_valid = 1'b0; irq_ext = 1'b0; irq_boundary = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
